// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and default sizes for the adder-sharing arbiter
package adder_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, searches upward from ptr+1
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      // Offset 1..NREQ so the last winner gets lowest priority.
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(i_ptr) + k) % NREQ;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin sharing of one WIDTH-bit adder among NREQ requesters
module adder_share_arb
   import adder_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_carry,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   state_t           r_state;
   state_t           w_next;
   logic [IDW-1:0]   r_ptr;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [IDW-1:0]   r_op_id;
   logic [WIDTH-1:0] r_rsp_sum;
   logic             r_rsp_carry;
   logic [IDW-1:0]   r_rsp_id;

   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_any;
   logic             w_accept;
   logic             w_done;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_accept = (r_state == ST_IDLE) && w_any && !rst;
   assign w_done   = (r_state == ST_RESP) && rsp_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any) w_next = ST_EXEC;
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= IDW'(NREQ - 1);
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_id     <= '0;
         r_rsp_sum   <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_id    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op_a  <= req_a[int'(w_idx)*WIDTH +: WIDTH];
            r_op_b  <= req_b[int'(w_idx)*WIDTH +: WIDTH];
            r_op_id <= w_idx;
         end
         if (r_state == ST_EXEC) begin
            {r_rsp_carry, r_rsp_sum} <= {1'b0, r_op_a} + {1'b0, r_op_b};
            r_rsp_id                 <= r_op_id;
         end
         // Pointer only advances once the result has actually been taken.
         if (w_done) r_ptr <= r_op_id;
      end
   end

   assign req_ready = w_accept ? w_grant : '0;
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_sum   = r_rsp_sum;
   assign rsp_carry = r_rsp_carry;
   assign rsp_id    = r_rsp_id;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - directed self-checking bench for adder_share_arb
module tb_adder_share_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_carry;
   logic [1:0]            rsp_id;
   logic                  busy;

   int n_tests = 0;
   int n_fail  = 0;

   adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   int         order [5]  = '{0, 1, 2, 3, 0};
   logic [7:0] fsum  [4]  = '{8'd11, 8'd22, 8'd33, 8'd44};

   initial begin
      rst       = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      #1;
      check("ready_in_reset", 32'(req_ready), 32'h0);
      step();
      step();
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_sum", 32'(rsp_sum), 32'h0);
      check("rst_carry", 32'(rsp_carry), 32'h0);
      check("rst_id", 32'(rsp_id), 32'h0);
      rst = 1'b0;
      req_valid = 4'b0000;

      // single request from requester 0
      set_op(0, 8'd4, 8'd2);
      req_valid = 4'b0001;
      #1;
      check("single_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 4'b0000;
      #1;
      check("single_exec_valid", 32'(rsp_valid), 32'h0);
      check("single_exec_busy", 32'(busy), 32'h1);
      check("single_exec_ready", 32'(req_ready), 32'h0);
      step();
      check("single_rsp_valid", 32'(rsp_valid), 32'h1);
      check("single_sum", 32'(rsp_sum), 32'd6);
      check("single_carry", 32'(rsp_carry), 32'h0);
      check("single_id", 32'(rsp_id), 32'h0);
      step();
      check("single_done", 32'(rsp_valid), 32'h0);

      // overflow on requester 2
      set_op(2, 8'hFF, 8'h01);
      req_valid = 4'b0100;
      #1;
      check("ovf_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = 4'b0000;
      step();
      check("ovf_sum", 32'(rsp_sum), 32'h00);
      check("ovf_carry", 32'(rsp_carry), 32'h1);
      check("ovf_id", 32'(rsp_id), 32'h2);
      step();

      // fairness after a fresh reset: grants 0,1,2,3,0 every 3 cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, 8'(10 * (i + 1)), 8'(i + 1));
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         #1;
         check($sformatf("fair_grant%0d", n), 32'(req_ready), 32'(1 << order[n]));
         step();
         check($sformatf("fair_exec%0d", n), 32'(rsp_valid), 32'h0);
         step();
         check($sformatf("fair_valid%0d", n), 32'(rsp_valid), 32'h1);
         check($sformatf("fair_id%0d", n), 32'(rsp_id), 32'(order[n]));
         check($sformatf("fair_sum%0d", n), 32'(rsp_sum), 32'(fsum[order[n]]));
         if (n == 4) req_valid = 4'b0000;
         step();
      end

      // back-pressure on requester 1: 0x80 + 0x90 = 0x110
      set_op(1, 8'h80, 8'h90);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      check("bp_grant", 32'(req_ready), 32'h2);
      step();
      step();
      for (int n = 0; n < 5; n++) begin
         check($sformatf("bp_valid%0d", n), 32'(rsp_valid), 32'h1);
         check($sformatf("bp_sum%0d", n), 32'(rsp_sum), 32'h10);
         check($sformatf("bp_carry%0d", n), 32'(rsp_carry), 32'h1);
         check($sformatf("bp_id%0d", n), 32'(rsp_id), 32'h1);
         check($sformatf("bp_ready%0d", n), 32'(req_ready), 32'h0);
         check($sformatf("bp_busy%0d", n), 32'(busy), 32'h1);
         step();
      end
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      #1;
      check("bp_release_valid", 32'(rsp_valid), 32'h1);
      step();
      check("bp_idle_busy", 32'(busy), 32'h0);
      check("bp_idle_valid", 32'(rsp_valid), 32'h0);

      // reset during EXEC discards the operation
      req_valid = 4'b0100;
      #1;
      check("mid_grant", 32'(req_ready), 32'h4);
      step();
      check("mid_exec_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      req_valid = 4'b0000;
      step();
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_sum", 32'(rsp_sum), 32'h0);
      check("mid_rst_carry", 32'(rsp_carry), 32'h0);
      rst = 1'b0;
      step();
      check("mid_no_rsp", 32'(rsp_valid), 32'h0);
      req_valid = 4'b1111;
      #1;
      check("mid_first_grant", 32'(req_ready), 32'h1);
      step();
      req_valid = 4'b0000;
      step();
      check("mid_rsp_id", 32'(rsp_id), 32'h0);
      check("mid_rsp_sum", 32'(rsp_sum), 32'd11);
      step();

      // requester 1 withdraws while requester 3 is in flight
      req_valid = 4'b1000;
      #1;
      check("wd_grant3", 32'(req_ready), 32'h8);
      step();
      req_valid = 4'b1010;
      #1;
      check("wd_exec_ready", 32'(req_ready), 32'h0);
      step();
      check("wd_resp_ready", 32'(req_ready), 32'h0);
      req_valid = 4'b0000;
      #1;
      check("wd_rsp_valid", 32'(rsp_valid), 32'h1);
      check("wd_rsp_id", 32'(rsp_id), 32'h3);
      check("wd_rsp_sum", 32'(rsp_sum), 32'd44);
      step();
      check("wd_no_grant1", 32'(req_ready), 32'h0);
      check("wd_idle", 32'(busy), 32'h0);
      step();
      check("wd_still_idle", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares a single WIDTH-bit adder among NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands, performs the add, and returns sum, carry and requester id on a valid/ready response channel. It sits between operand-producing units and the shared adder datapath, and it is the only path by which those units reach the adder.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand and sum width
- IDW, $clog2(NREQ), requester id width (derived, not overridden)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH
- rsp_carry  out  1  carry out of the WIDTH-bit add
- rsp_id  out  IDW  index of the requester that owns the result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: if any req_valid is high, pick grant g = first set req_valid bit searching upward from ptr+1, wrapping modulo NREQ. Drive req_ready[g]=1 combinationally in the same cycle. Capture req_a[g], req_b[g] and g into op_a, op_b, op_id. Go to EXEC. If no req_valid is high, stay in IDLE.
  - EXEC: register {rsp_carry, rsp_sum} <= op_a + op_b (WIDTH+1-bit add, zero-extended operands) and rsp_id <= op_id. Go to RESP.
  - RESP: hold rsp_valid=1. On rsp_valid & rsp_ready, set ptr <= op_id and go to IDLE.
- req_ready is 0 in EXEC and RESP. No new request is accepted until the response handshake completes.
- A requester that drops req_valid before it is granted is never served and causes no error.
- rsp_sum, rsp_carry and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Round-robin fairness: a requester holding req_valid high is granted within NREQ grants.

## Timing
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 has first priority), req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
- Latency: request accepted at edge T (IDLE, req_ready high); rsp_valid high from cycle T+2.
- Throughput: one operation per 3 cycles when rsp_ready is held high (IDLE→EXEC→RESP→IDLE).
- Response back-pressure: RESP persists for any number of cycles. The next grant occurs in the first IDLE cycle after the handshake.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded without a response, and all outputs take their reset values on the next edge.
- Simultaneous requests: only the round-robin winner sees req_ready. All other requesters must hold their operands stable.
- Overflow: 8'hFF + 8'h01 → rsp_sum=8'h00, rsp_carry=1. No saturation.

## Structure
- Package adder_arb_pkg holds:
  - the state enum (IDLE, EXEC, RESP), encoded 2'b00/01/10
  - default NREQ and WIDTH constants
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: grant one-hot, grant index, any.
  - Parameterised on NREQ.
- Top-level adder_share_arb contains the FSM, operand and result registers, and the adder expression.

## Test plan
- Reset then single request: req_valid=4'b0001, a=4, b=2 → req_ready[0] high one cycle; rsp_valid 2 cycles later with sum=6, carry=0, id=0.
- Overflow: requester 2 sends a=8'hFF, b=8'h01 → sum=8'h00, carry=1, id=2.
- Fairness: all four req_valid held high with distinct operands and rsp_ready=1 → grant order 0,1,2,3,0; new grant every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP → rsp outputs stable, req_ready stays 0, busy=1; the handshake then returns to IDLE.
- Reset mid-op: assert rst during EXEC → no rsp_valid; next request from requester 0 is served first.
- Withdrawn request: requester 1 raises then drops req_valid while the block is busy → it is never granted, and the requester 3 request completes normally.
